// File: rtl/instr_mem_loader.sv
// Boot-time instruction loader: packs a big-endian byte stream into 32-bit words,
// writes them from address 0 upward and keeps the processor in reset until the image is in.
module instr_mem_loader #(
    parameter int ADDR_W      = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, HOLD, DONE} state_t;

    state_t            state;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   addr_q;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start_ok;

    assign start_ok = start && (word_count != '0) && (word_count <= DEPTH);

    // NOTE: every register here uses non-blocking assignment so all state sees the
    // pre-edge values of its neighbours; blocking would make ordering matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            byte_cnt  <= '0;
            shift_q   <= '0;
            hold_cnt  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state    <= RECV;
                        count_q  <= word_count;
                        addr_q   <= '0;
                        byte_cnt <= '0;
                        shift_q  <= '0;
                        error    <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                    end else if (start) begin
                        error <= 1'b1;
                    end
                end

                RECV: begin
                    // in_ready is always high in RECV, so in_valid alone marks acceptance
                    if (in_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {shift_q[15:0], in_data};
                        if (byte_cnt == 2'd3) begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q[ADDR_W-1:0];
                            mem_wdata <= {shift_q, in_data};
                        end
                    end
                end

                WRITE: begin
                    addr_q <= addr_q + ADDR_ONE;
                    if (addr_q + ADDR_ONE == count_q) begin
                        if (HOLD_CYCLES == 0) begin
                            state   <= DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end

                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= DONE;
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as each word's
// fourth byte is accepted and matched against mem_we pulses.
module tb_instr_mem_loader;

    localparam int ADDR_W      = 10;
    localparam int HOLD_CYCLES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;

    int  checks    = 0;
    int  failures  = 0;
    int  cyc       = 0;
    int  n_writes  = 0;
    int  last_we_cyc = 0;
    int  t_start   = 0;
    int  done_cyc  = 0;
    logic prev_we  = 1'b0;
    wr_t exp_q[$];

    instr_mem_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we must be a lone pulse matching the queue head.
    always @(negedge clk) begin
        wr_t w;
        if (rst && mem_we) begin
            n_writes++;
            check("we_pulse", 64'(prev_we), 64'd0);
            check("ready_in_write", 64'(in_ready), 64'd0);
            check("cpu_rst_in_write", 64'(cpu_rst), 64'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(mem_we), 64'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(w.addr));
                check("wr_data", 64'(mem_wdata), 64'(w.data));
            end
            last_we_cyc = cyc;
        end
        prev_we = mem_we;
    end

    task automatic do_start(input logic [ADDR_W:0] cnt);
        start      = 1'b1;
        word_count = cnt;
        @(posedge clk);
        #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("byte_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(data[31-8*i -: 8]);
            if (gap && i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
        done_cyc = cyc;
    endtask

    task automatic check_released(input string tag);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, 64'(done_cyc - last_we_cyc), 64'(HOLD_CYCLES + 1));
        check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] last_data;
        rst = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Rejected starts from IDLE
        do_start(0);
        check("err0_error", 64'(error), 64'd1);
        check("err0_busy", 64'(busy), 64'd0);
        check("err0_ready", 64'(in_ready), 64'd0);
        do_start(11'd1025);
        check("err1025_error", 64'(error), 64'd1);
        check("err1025_busy", 64'(busy), 64'd0);
        check("err1025_ready", 64'(in_ready), 64'd0);
        check("err1025_cpu_rst", 64'(cpu_rst), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("err_no_writes", 64'(n_writes), 64'd0);

        // Two back-to-back words
        do_start(2);
        check("s2_error_clr", 64'(error), 64'd0);
        check("s2_busy", 64'(busy), 64'd1);
        check("s2_ready", 64'(in_ready), 64'd1);
        send_word(0, 32'h2022_0005, 1'b0);
        send_word(1, 32'h8C41_0008, 1'b0);
        wait_done(100);
        check_released("s2");
        check("s2_rate", 64'(last_we_cyc - t_start), 64'd9);

        // DONE ignores input bytes and keeps state on a rejected start
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("done_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        do_start(0);
        check("done_err", 64'(error), 64'd1);
        check("done_err_done", 64'(done), 64'd1);
        check("done_err_cpu_rst", 64'(cpu_rst), 64'd0);
        check("done_writes", 64'(n_writes), 64'd2);

        // Reload from DONE; a start while busy must be ignored
        do_start(1);
        check("rl_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rl_done", 64'(done), 64'd0);
        check("rl_error", 64'(error), 64'd0);
        send_byte(8'hCA);
        send_byte(8'hFE);
        do_start(5);
        check("rl_busy_start_err", 64'(error), 64'd0);
        check("rl_busy_start_busy", 64'(busy), 64'd1);
        send_byte(8'hF0);
        send_byte(8'h0D);
        exp_q.push_back('{addr: '0, data: 32'hCAFE_F00D});
        wait_done(100);
        check_released("rl");

        // in_valid toggled every other cycle
        do_start(1);
        send_word(0, 32'hDEAD_BEEF, 1'b1);
        wait_done(100);
        check_released("gap");

        // Reset mid-word discards the partial word
        do_start(1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst = 1'b0;
        #1;
        check("mid_ready", 64'(in_ready), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_cpu_rst", 64'(cpu_rst), 64'd1);
        check("mid_wdata", 64'(mem_wdata), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_start(1);
        send_word(0, 32'h1122_3344, 1'b0);
        wait_done(100);
        check_released("mid");

        // Full-depth load: addresses 0..DEPTH-1, no wrap
        do_start(11'd1024);
        last_data = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            last_data = $urandom;
            send_word(ADDR_W'(i), last_data, 1'b0);
        end
        wait_done(100);
        check_released("full");
        check("full_rate", 64'(last_we_cyc - t_start), 64'(5 * 1023 + 4));
        check("full_addr_hold", 64'(mem_addr), 64'd1023);
        check("full_data_hold", 64'(mem_wdata), 64'(last_data));
        check("total_writes", 64'(n_writes), 64'(2 + 1 + 1 + 1 + 1024));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (DEPTH = 2^ADDR_W words).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles cpu_rst stays high after the last word is written.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port word_count  input  ADDR_W+1  number of words to load; sampled only when start is accepted.
REQ-007 SHALL have port in_valid  input  1  byte-stream valid from the host.
REQ-008 SHALL have port in_data  input  8  byte-stream data.
REQ-009 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-012 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port cpu_rst  output  1  active-high reset to the processor's PC and register file.
REQ-014 SHALL have port busy  output  1  session in progress.
REQ-015 SHALL have port done  output  1  image loaded and processor released.
REQ-016 SHALL have port error  output  1  last start rejected.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE, HOLD, DONE.
REQ-018 IDLE: in_ready=0, cpu_rst=1; on start with 1 <= word_count <= DEPTH -> RECV, latch word_count, clear byte counter, word address=0, error=0.
REQ-019 IDLE/DONE: on start with word_count=0 or >DEPTH -> set error=1, remain in the current state, cpu_rst and done unchanged.
REQ-020 RECV: in_ready=1, busy=1; byte accepted when in_valid&&in_ready; bytes assembled big-endian (1st byte -> [31:24], 4th -> [7:0]).
REQ-021 On acceptance of the 4th byte -> WRITE next cycle; in_ready SHALL be 0 in WRITE.
REQ-022 WRITE: mem_we=1 for exactly one cycle with mem_addr=current word address, mem_wdata=assembled word; then address increments.
REQ-023 After WRITE: written count == latched count -> HOLD; else -> RECV.
REQ-024 Address SHALL NOT wrap; count=DEPTH writes addresses 0..DEPTH-1 and stops.
REQ-025 mem_we SHALL be 0 in every state except WRITE; mem_addr/mem_wdata SHALL hold their last values outside WRITE.
REQ-026 HOLD: cpu_rst=1 for HOLD_CYCLES cycles, busy=1, then -> DONE.
REQ-027 DONE: cpu_rst=0, done=1, busy=0, in_ready=0; in_valid ignored.
REQ-028 DONE + valid start: next cycle cpu_rst=1, done=0, state RECV (reload).
REQ-029 start while busy SHALL be ignored (no error, no restart).
REQ-030 Throughput: minimum 5 cycles per word (4 accept + 1 write); in_valid gaps SHALL only stall RECV.

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, counters=0.
REQ-032 Reset mid-session SHALL discard any partial word; no write SHALL occur for it after rst deasserts.

Verification
REQ-033 start, word_count=2, bytes 20 22 00 05 8C 41 00 08 back-to-back -> writes 0x20220005@0 and 0x8C410008@1, each one-cycle mem_we; cpu_rst falls 4 cycles after 2nd write; done=1.
REQ-034 word_count=1, in_valid toggled every other cycle -> one write 0xDEADBEEF@0 only after 4th accepted byte; mem_we never asserted during gaps.
REQ-035 start with word_count=0, then 1025 (ADDR_W=10) -> error=1, state IDLE, in_ready=0, no writes.
REQ-036 rst low after 2 bytes of word 1 -> outputs at reset values same edge-independent; after rst high and new start count=1, first write lands at address 0 with new bytes only.
REQ-037 From DONE, start count=1 -> cpu_rst=1 and done=0 next cycle, write @0, release again after HOLD_CYCLES; start pulsed during RECV has no effect.
